update_tick_adapter: RTL and testbench
======================================

UPDATE_TICK_ADAPTER -- requirements
Module: update_tick_adapter

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of independent update channels (1..16).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set synchronizer depth per channel (2..4).
REQ-003 Parameter MISS_W, default 8, SHALL set the width of each per-channel missed-event counter.
REQ-004 processor_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 update_clk  input  NUM_CH  asynchronous slow update strobes, one per channel.
REQ-007 ack  input  NUM_CH  per-channel acknowledge from the consumer of pending.
REQ-008 clr_miss  input  1  synchronous clear of all miss counters.
REQ-009 must_update  output  NUM_CH  one-cycle pulse per detected rising edge of update_clk.
REQ-010 pending  output  NUM_CH  sticky per-channel update request, held until acknowledged.
REQ-011 overrun  output  NUM_CH  one-cycle pulse when a new edge arrives while pending is set and not being acknowledged.
REQ-012 miss_count  output  NUM_CH*MISS_W  channel c occupies bits [c*MISS_W +: MISS_W].

Function
REQ-013 Each channel SHALL pass update_clk[c] through a SYNC_STAGES-deep flop chain, then a history flop; rise[c] = sync_out & ~history.
REQ-014 must_update[c] SHALL be registered from rise[c]; first sampling edge k of a high level gives must_update[c] high for exactly one cycle after edge k+SYNC_STAGES.
REQ-015 A level held high for any number of cycles SHALL produce exactly one must_update pulse; a new pulse requires a low sample first.
REQ-016 pending[c] SHALL set on the same edge must_update[c] rises and clear on the edge after ack[c] is sampled high.
REQ-017 ack[c] while pending[c] is low SHALL be ignored.
REQ-018 Rise and ack on the same edge with pending set: pending SHALL stay set, no overrun, no miss count.
REQ-019 Rise without ack while pending set: overrun[c] SHALL pulse with must_update[c], pending stays set, miss counter increments.
REQ-020 Miss counters SHALL saturate at 2^MISS_W-1, never wrap.
REQ-021 clr_miss SHALL zero all counters on the next edge; clr_miss and a miss on the same edge SHALL give 0.
REQ-022 Channels SHALL be fully independent; simultaneous events on all channels SHALL each be handled per REQ-013..021.

Reset
REQ-023 reset low SHALL immediately clear all synchronizer, history, must_update, pending, overrun and miss_count state to 0.
REQ-024 Release SHALL not generate a pulse for an update_clk already high; the first pulse requires a 0 then 1 sample after release.
REQ-025 Reset asserted mid-event SHALL discard the event with no pulse after release unless REQ-024 is satisfied.

Configuration
REQ-026 Macro UPDATE_MISS_COUNT_EN defined: miss counters and clr_miss logic SHALL be built per REQ-019..021.
REQ-027 Macro undefined: miss_count SHALL be constant 0, clr_miss ignored; must_update, pending and overrun unchanged.

Verification
REQ-028 SYNC_STAGES=2, update_clk[0] 0->1 sampled edge 10, held 50 cycles -> must_update[0] high only cycle after edge 12; pending[0]=1 from edge 12.
REQ-029 Pending[1] set, ack[1] pulsed one cycle at edge 20 -> pending[1]=0 after edge 20; ack[1] again at edge 30 -> no change.
REQ-030 Pending[2] set, second edge no ack -> overrun[2] one cycle, miss_count[2]=1; 300 such edges with MISS_W=8 -> 255.
REQ-031 Rise and ack coincide on channel 3 -> pending[3] stays 1, overrun[3]=0, miss_count[3] unchanged.
REQ-032 update_clk=all ones at reset release -> no must_update; after all-zero then all-ones, all NUM_CH pulse on the same cycle.
REQ-033 Macro undefined, REQ-030 stimulus -> overrun[2] pulses, miss_count stays 0.

Source files
------------

// File: rtl/update_tick_adapter_if.sv
// Handshake bundle for update_tick_adapter.
// The master side drives the update strobes, acks and the miss-clear.
// The slave side (the adapter) returns the pulses, the sticky requests and the miss counters.
interface update_tick_adapter_if #(
  parameter int NUM_CH = 4,
  parameter int MISS_W = 8
);
  logic [NUM_CH-1:0]        update_clk;
  logic [NUM_CH-1:0]        ack;
  logic                     clr_miss;
  logic [NUM_CH-1:0]        must_update;
  logic [NUM_CH-1:0]        pending;
  logic [NUM_CH-1:0]        overrun;
  logic [NUM_CH*MISS_W-1:0] miss_count;

  modport master (
    output update_clk, ack, clr_miss,
    input  must_update, pending, overrun, miss_count
  );

  modport slave (
    input  update_clk, ack, clr_miss,
    output must_update, pending, overrun, miss_count
  );
endinterface

// File: rtl/update_tick_adapter.sv
// update_tick_adapter: turns slow, asynchronous per-channel update strobes into
// single-cycle must_update pulses in the processor_clk domain.
// Each channel also keeps a sticky pending request that is cleared by ack.
// An overrun pulse fires when a new edge arrives while the request is still
// pending and is not being acknowledged.
// Optional feature macro: UPDATE_MISS_COUNT_EN. When it is defined, each
// channel gets a saturating missed-event counter that clr_miss clears.
// When it is undefined, miss_count is tied to zero and clr_miss is ignored.
module update_tick_adapter #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MISS_W      = 8
) (
  input  logic                 processor_clk,
  input  logic                 reset,
  update_tick_adapter_if.slave bus
);

  // Goes all-ones SYNC_STAGES cycles after reset release. From then on, the
  // chain outputs reflect real samples rather than reset zeros.
  logic [SYNC_STAGES-1:0]   r_live;
  logic                     w_valid;
  logic [NUM_CH-1:0]        w_must;
  logic [NUM_CH-1:0]        w_pend;
  logic [NUM_CH-1:0]        w_ovr;
  logic [NUM_CH*MISS_W-1:0] w_miss;

  // Fill indicator for the synchronizer chains after reset
  always_ff @(posedge processor_clk or negedge reset) begin
    if (!reset) r_live <= '0;
    else        r_live <= {r_live[SYNC_STAGES-2:0], 1'b1};
  end

  assign w_valid = r_live[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_hist;
      logic                   r_armed;
      logic                   r_must;
      logic                   r_pend;
      logic                   r_ovr;
      logic                   w_sync_out;
      logic                   w_rise;
      logic                   w_miss_evt;

      assign w_sync_out = r_sync[SYNC_STAGES-1];
      // The armed flag holds off any edge until a genuine low sample has been
      // seen after reset. A level that is already high at release (or a
      // half-seen event cut by reset) therefore never pulses.
      assign w_rise     = w_sync_out & ~r_hist & r_armed;
      assign w_miss_evt = w_rise & r_pend & ~bus.ack[gi];

      // Metastability chain for the asynchronous strobe
      always_ff @(posedge processor_clk or negedge reset) begin
        if (!reset) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.update_clk[gi]};
      end

      // Edge history, arming, pulse, sticky request and overrun
      always_ff @(posedge processor_clk or negedge reset) begin
        if (!reset) begin
          r_hist  <= 1'b0;
          r_armed <= 1'b0;
          r_must  <= 1'b0;
          r_pend  <= 1'b0;
          r_ovr   <= 1'b0;
        end else begin
          r_hist  <= w_sync_out;
          r_armed <= r_armed | (w_valid & ~w_sync_out);
          r_must  <= w_rise;
          // A new edge wins over a simultaneous ack, so the request stays set
          r_pend  <= w_rise | (r_pend & ~bus.ack[gi]);
          r_ovr   <= w_miss_evt;
        end
      end

      assign w_must[gi] = r_must;
      assign w_pend[gi] = r_pend;
      assign w_ovr[gi]  = r_ovr;

`ifdef UPDATE_MISS_COUNT_EN
      logic [MISS_W-1:0] r_miss;

      // Saturating miss counter; the clear takes priority over a same-edge miss
      always_ff @(posedge processor_clk or negedge reset) begin
        if (!reset)                           r_miss <= '0;
        else if (bus.clr_miss)                r_miss <= '0;
        else if (w_miss_evt && (r_miss != '1)) r_miss <= r_miss + 1'b1;
      end

      assign w_miss[gi*MISS_W +: MISS_W] = r_miss;
`else
      assign w_miss[gi*MISS_W +: MISS_W] = '0;
`endif
    end
  endgenerate

`ifndef UPDATE_MISS_COUNT_EN
  // The clear has nothing to act on when there are no counters
  logic w_unused_clr;
  assign w_unused_clr = bus.clr_miss;
`endif

  assign bus.must_update = w_must;
  assign bus.pending     = w_pend;
  assign bus.overrun     = w_ovr;
  assign bus.miss_count  = w_miss;

endmodule

// File: tb/tb_update_tick_adapter.sv
// Testbench for update_tick_adapter.
// Stimulus is directed. A sample-history model predicts every output on every
// clock, and a few literal expectations pin specific events.
module tb_update_tick_adapter;
  localparam int NUM_CH = 4;
  localparam int S      = 2;
  localparam int MISS_W = 8;
  localparam int MISS_MAX = (1 << MISS_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  update_tick_adapter_if #(.NUM_CH(NUM_CH), .MISS_W(MISS_W)) bus ();

  update_tick_adapter #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(S), .MISS_W(MISS_W)
  ) dut (
    .processor_clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Input samples taken since reset release (oldest first, last S+2 kept).
  logic [NUM_CH-1:0] samp_q[$];
  logic [NUM_CH-1:0] m_must, m_pend, m_ovr, m_rise;
  int m_miss [NUM_CH];

  function automatic logic [NUM_CH*MISS_W-1:0] miss_vec();
    logic [NUM_CH*MISS_W-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c*MISS_W +: MISS_W] = MISS_W'(m_miss[c]);
    return v;
  endfunction

  // An edge is reported S clocks after the first high sample. It needs the
  // immediately preceding sample to be low, and both samples must be post-reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      samp_q.delete();
      m_must = '0; m_pend = '0; m_ovr = '0;
      for (int c = 0; c < NUM_CH; c++) m_miss[c] = 0;
    end else begin
      samp_q.push_back(bus.update_clk);
      if (samp_q.size() > S + 2) void'(samp_q.pop_front());
      if (samp_q.size() == S + 2) m_rise = samp_q[1] & ~samp_q[0];
      else                        m_rise = '0;
      m_ovr = m_rise & m_pend & ~bus.ack;
`ifdef UPDATE_MISS_COUNT_EN
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.clr_miss)                        m_miss[c] = 0;
        else if (m_ovr[c] && m_miss[c] < MISS_MAX) m_miss[c] = m_miss[c] + 1;
      end
`endif
      m_pend = m_rise | (m_pend & ~bus.ack);
      m_must = m_rise;
    end
    #1;
    chk("must_update", 64'(bus.must_update), 64'(m_must));
    chk("pending",     64'(bus.pending),     64'(m_pend));
    chk("overrun",     64'(bus.overrun),     64'(m_ovr));
    chk("miss_count",  64'(bus.miss_count),  64'(miss_vec()));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise a channel and stop just after the clock edge where its pulse appears
  task automatic rise_to_pulse(input int c);
    bus.update_clk[c] = 1'b1;
    cyc(S + 1);
  endtask

  task automatic drop(input int c);
    bus.update_clk[c] = 1'b0;
    cyc(1);
  endtask

  int exp_miss;

  initial begin
    bus.update_clk = '0;
    bus.ack = '0;
    bus.clr_miss = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_must", 64'(bus.must_update), 64'h0);
    chk("reset_pend", 64'(bus.pending), 64'h0);
    chk("reset_miss", 64'(bus.miss_count), 64'h0);
    cyc(3);
    rst_n = 1'b1;
    cyc(4);

    // Channel 0: single pulse S edges after the first high sample, level held 50 cycles
    bus.update_clk[0] = 1'b1;
    cyc(S);
    chk("ch0_before_pulse", 64'(bus.must_update[0]), 64'h0);
    cyc(1);
    chk("ch0_pulse", 64'(bus.must_update), 64'h1);
    chk("ch0_pend", 64'(bus.pending[0]), 64'h1);
    chk("model_ch0_pulse", 64'(m_must), 64'h1);
    cyc(1);
    chk("ch0_pulse_end", 64'(bus.must_update[0]), 64'h0);
    cyc(48);
    chk("ch0_held_pend", 64'(bus.pending[0]), 64'h1);
    bus.update_clk[0] = 1'b0;
    bus.ack[0] = 1'b1;
    cyc(1);
    bus.ack[0] = 1'b0;
    chk("ch0_acked", 64'(bus.pending[0]), 64'h0);

    // Channel 1: ack clears; ack while idle is ignored
    rise_to_pulse(1);
    chk("ch1_pend_set", 64'(bus.pending[1]), 64'h1);
    drop(1);
    bus.ack[1] = 1'b1;
    cyc(1);
    bus.ack[1] = 1'b0;
    chk("ch1_ack_clear", 64'(bus.pending[1]), 64'h0);
    cyc(9);
    bus.ack[1] = 1'b1;
    cyc(1);
    bus.ack[1] = 1'b0;
    chk("ch1_ack_idle", 64'(bus.pending[1]), 64'h0);
    chk("ch1_no_pulse", 64'(bus.must_update[1]), 64'h0);

    // Channel 2: overrun and saturating miss count
    rise_to_pulse(2);
    chk("ch2_first_no_ovr", 64'(bus.overrun[2]), 64'h0);
    drop(2);
    rise_to_pulse(2);
`ifdef UPDATE_MISS_COUNT_EN
    exp_miss = 1;
`else
    exp_miss = 0;
`endif
    chk("ch2_overrun", 64'(bus.overrun[2]), 64'h1);
    chk("ch2_miss1", 64'(bus.miss_count[2*MISS_W +: MISS_W]), 64'(exp_miss));
    chk("model_ch2_miss1", 64'(m_miss[2]), 64'(exp_miss));
    cyc(1);
    chk("ch2_overrun_end", 64'(bus.overrun[2]), 64'h0);
    for (int i = 0; i < 300; i++) begin
      bus.update_clk[2] = 1'b0;
      cyc(1);
      bus.update_clk[2] = 1'b1;
      cyc(1);
    end
    bus.update_clk[2] = 1'b0;
    cyc(S + 2);
`ifdef UPDATE_MISS_COUNT_EN
    exp_miss = 255;
`else
    exp_miss = 0;
`endif
    chk("ch2_miss_sat", 64'(bus.miss_count[2*MISS_W +: MISS_W]), 64'(exp_miss));
    chk("model_ch2_sat", 64'(m_miss[2]), 64'(exp_miss));

    // A clear that lands on the same edge as a miss leaves zero
    bus.update_clk[2] = 1'b1;
    cyc(S);
    bus.clr_miss = 1'b1;
    cyc(1);
    bus.clr_miss = 1'b0;
    chk("clr_same_edge_ovr", 64'(bus.overrun[2]), 64'h1);
    chk("clr_same_edge_miss", 64'(bus.miss_count), 64'h0);
    drop(2);
    rise_to_pulse(2);
`ifdef UPDATE_MISS_COUNT_EN
    exp_miss = 1;
`else
    exp_miss = 0;
`endif
    chk("ch2_miss_after_clr", 64'(bus.miss_count[2*MISS_W +: MISS_W]), 64'(exp_miss));
    drop(2);
    bus.clr_miss = 1'b1;
    cyc(1);
    bus.clr_miss = 1'b0;
    chk("clr_plain", 64'(bus.miss_count), 64'h0);

    // Channel 3: a rise coinciding with ack keeps pending, with no overrun
    rise_to_pulse(3);
    drop(3);
    bus.update_clk[3] = 1'b1;
    cyc(S);
    bus.ack[3] = 1'b1;
    cyc(1);
    bus.ack[3] = 1'b0;
    chk("ch3_pulse", 64'(bus.must_update[3]), 64'h1);
    chk("ch3_pend_kept", 64'(bus.pending[3]), 64'h1);
    chk("ch3_no_ovr", 64'(bus.overrun[3]), 64'h0);
    chk("ch3_miss_same", 64'(bus.miss_count[3*MISS_W +: MISS_W]), 64'h0);
    drop(3);

    // Reset mid-event with all strobes high, then release with them still high
    bus.update_clk = '1;
    cyc(1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_pend", 64'(bus.pending), 64'h0);
    chk("async_reset_must", 64'(bus.must_update), 64'h0);
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    chk("release_high_no_pulse", 64'(bus.pending), 64'h0);
    bus.update_clk = '0;
    cyc(2);
    bus.update_clk = '1;
    cyc(S);
    chk("all_before", 64'(bus.must_update), 64'h0);
    cyc(1);
    chk("all_pulse", 64'(bus.must_update), 64'hf);
    chk("all_pend", 64'(bus.pending), 64'hf);
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
